// File: rtl/nv_nvdla_csb_pkg.sv
// Shared constants and FSM encoding for the CSB arbiter slice.
package nv_nvdla_csb_pkg;

  localparam int unsigned CsbAddrW = 16;
  localparam int unsigned CsbDataW = 32;

  localparam logic [CsbDataW-1:0] CsbTimeoutData = 32'h0;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } csb_arb_state_e;

endpackage

// File: rtl/nv_nvdla_csb_arb_if.sv
// Bundle of the per-requester channels and the shared CSB target port.
interface nv_nvdla_csb_arb_if
  import nv_nvdla_csb_pkg::*;
#(
  parameter int unsigned NREQ = 2
);

  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ*CsbAddrW-1:0] req_addr;
  logic [NREQ*CsbDataW-1:0] req_wdat;
  logic [NREQ-1:0]          req_write;
  logic [NREQ-1:0]          req_nposted;
  logic [NREQ-1:0]          rsp_valid;
  logic [CsbDataW-1:0]      rsp_data;
  logic                     rsp_error;

  logic                     csb2nvdla_valid;
  logic                     csb2nvdla_ready;
  logic [CsbAddrW-1:0]      csb2nvdla_addr;
  logic [CsbDataW-1:0]      csb2nvdla_wdat;
  logic                     csb2nvdla_write;
  logic                     csb2nvdla_nposted;
  logic                     nvdla2csb_valid;
  logic [CsbDataW-1:0]      nvdla2csb_data;
  logic                     nvdla2csb_wr_complete;

  // Environment view: requesters plus the CSB target.
  modport master (
    output req_valid, req_addr, req_wdat, req_write, req_nposted,
    output csb2nvdla_ready, nvdla2csb_valid, nvdla2csb_data, nvdla2csb_wr_complete,
    input  req_ready, rsp_valid, rsp_data, rsp_error,
    input  csb2nvdla_valid, csb2nvdla_addr, csb2nvdla_wdat, csb2nvdla_write, csb2nvdla_nposted
  );

  // Arbiter view.
  modport slave (
    input  req_valid, req_addr, req_wdat, req_write, req_nposted,
    input  csb2nvdla_ready, nvdla2csb_valid, nvdla2csb_data, nvdla2csb_wr_complete,
    output req_ready, rsp_valid, rsp_data, rsp_error,
    output csb2nvdla_valid, csb2nvdla_addr, csb2nvdla_wdat, csb2nvdla_write, csb2nvdla_nposted
  );

endinterface

// File: rtl/nv_nvdla_rr_pick.sv
// Combinational round-robin picker: first requester after `last` (mod NREQ) wins.
module nv_nvdla_rr_pick #(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IdxW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IdxW-1:0] last,
  output logic [NREQ-1:0] gnt,
  output logic [IdxW-1:0] idx
);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      int unsigned j;
      j = (32'(last) + off) % NREQ;
      if (!found && req[IdxW'(j)]) begin
        found           = 1'b1;
        gnt[IdxW'(j)]   = 1'b1;
        idx             = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/nv_nvdla_csb_arb.sv
// Round-robin arbiter sharing one CSB target port among NREQ requesters,
// one non-interleaved transaction at a time, with response timeout.
module nv_nvdla_csb_arb
  import nv_nvdla_csb_pkg::*;
#(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned TO_CYC = 1023
) (
  input logic              pclk,
  input logic              prst,
  nv_nvdla_csb_arb_if.slave bus
);

  localparam int unsigned IdxW = $clog2(NREQ);
  localparam int unsigned CntW = $clog2(TO_CYC + 1);

  csb_arb_state_e      state_q, state_d;
  logic [IdxW-1:0]     last_gnt_q, owner_q;
  logic [CsbAddrW-1:0] addr_q;
  logic [CsbDataW-1:0] wdat_q;
  logic                write_q, nposted_q;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [CsbDataW-1:0] rsp_data_q, rsp_data_d;
  logic                rsp_error_q, rsp_error_d;
  logic                rsp_fire;
  logic                grant;
  logic [NREQ-1:0]     pick_gnt;
  logic [IdxW-1:0]     pick_idx;

  nv_nvdla_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req  (bus.req_valid),
    .last (last_gnt_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    grant         = 1'b0;
    rsp_fire      = 1'b0;
    rsp_data_d    = rsp_data_q;
    rsp_error_d   = rsp_error_q;
    bus.req_ready = '0;
    bus.csb2nvdla_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|pick_gnt) begin
          grant         = 1'b1;
          bus.req_ready = pick_gnt;
          state_d       = StIssue;
        end
      end
      StIssue: begin
        bus.csb2nvdla_valid = 1'b1;
        if (bus.csb2nvdla_ready) begin
          if (write_q && !nposted_q) begin
            state_d = StIdle;
          end else begin
            state_d = StWait;
            cnt_d   = '0;
          end
        end
      end
      StWait: begin
        if (cnt_q != CntW'(TO_CYC)) cnt_d = cnt_q + CntW'(1);
        // A matching response beats a timeout in the same cycle.
        if (!write_q && bus.nvdla2csb_valid) begin
          rsp_fire    = 1'b1;
          rsp_data_d  = bus.nvdla2csb_data;
          rsp_error_d = 1'b0;
        end else if (write_q && bus.nvdla2csb_wr_complete) begin
          rsp_fire    = 1'b1;
          rsp_data_d  = '0;
          rsp_error_d = 1'b0;
        end else if (cnt_q == CntW'(TO_CYC - 1)) begin
          rsp_fire    = 1'b1;
          rsp_data_d  = CsbTimeoutData;
          rsp_error_d = 1'b1;
        end
        if (rsp_fire) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    rsp_valid_d = rsp_fire ? ({{(NREQ-1){1'b0}}, 1'b1} << owner_q) : '0;
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      last_gnt_q  <= IdxW'(NREQ - 1);
      owner_q     <= '0;
      addr_q      <= '0;
      wdat_q      <= '0;
      write_q     <= 1'b0;
      nposted_q   <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
      if (grant) begin
        last_gnt_q <= pick_idx;
        owner_q    <= pick_idx;
        addr_q     <= bus.req_addr[32'(pick_idx)*CsbAddrW +: CsbAddrW];
        wdat_q     <= bus.req_wdat[32'(pick_idx)*CsbDataW +: CsbDataW];
        write_q    <= bus.req_write[pick_idx];
        nposted_q  <= bus.req_nposted[pick_idx];
      end
    end
  end

  assign bus.csb2nvdla_addr    = addr_q;
  assign bus.csb2nvdla_wdat    = wdat_q;
  assign bus.csb2nvdla_write   = write_q;
  assign bus.csb2nvdla_nposted = nposted_q;
  assign bus.rsp_valid         = rsp_valid_q;
  assign bus.rsp_data          = rsp_data_q;
  assign bus.rsp_error         = rsp_error_q;

endmodule

// File: tb/tb_nv_nvdla_csb_arb.sv
// Directed bench for nv_nvdla_csb_arb with NREQ=2, TO_CYC=15.
module tb_nv_nvdla_csb_arb;

  logic pclk;
  logic prst;
  int   total;
  int   bad;

  nv_nvdla_csb_arb_if #(.NREQ(2)) bus ();

  nv_nvdla_csb_arb #(
    .NREQ   (2),
    .TO_CYC (15)
  ) dut (
    .pclk (pclk),
    .prst (prst),
    .bus  (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    prst  = 1'b1;
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.req_wdat = '0;
    bus.req_write = '0;
    bus.req_nposted = '0;
    bus.csb2nvdla_ready = 1'b0;
    bus.nvdla2csb_valid = 1'b0;
    bus.nvdla2csb_data = '0;
    bus.nvdla2csb_wr_complete = 1'b0;

    // Reset values.
    #2;
    chk("rst_csb_valid", 32'(bus.csb2nvdla_valid), 32'd0);
    chk("rst_csb_addr", 32'(bus.csb2nvdla_addr), 32'd0);
    chk("rst_csb_wdat", bus.csb2nvdla_wdat, 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_rsp_error", 32'(bus.rsp_error), 32'd0);
    #10 prst = 1'b0;
    nxt();

    // Posted write from requester 0.
    bus.req_valid = 2'b01;
    bus.req_addr = {16'h0000, 16'h0010};
    bus.req_wdat = {32'h0, 32'hA5A5_0001};
    bus.req_write = 2'b01;
    bus.req_nposted = 2'b00;
    bus.csb2nvdla_ready = 1'b1;
    #1 chk("pw_req_ready", 32'(bus.req_ready), 32'b01);
    nxt();
    bus.req_valid = 2'b00;
    #1;
    chk("pw_csb_valid", 32'(bus.csb2nvdla_valid), 32'd1);
    chk("pw_csb_addr", 32'(bus.csb2nvdla_addr), 32'h0010);
    chk("pw_csb_wdat", bus.csb2nvdla_wdat, 32'hA5A5_0001);
    chk("pw_csb_write", 32'(bus.csb2nvdla_write), 32'd1);
    chk("pw_csb_nposted", 32'(bus.csb2nvdla_nposted), 32'd0);
    chk("pw_req_ready_low", 32'(bus.req_ready), 32'd0);
    nxt();
    chk("pw_csb_valid_drop", 32'(bus.csb2nvdla_valid), 32'd0);
    chk("pw_no_rsp0", 32'(bus.rsp_valid), 32'd0);
    nxt();
    chk("pw_no_rsp1", 32'(bus.rsp_valid), 32'd0);

    // Read from requester 1, ready stalled 3 cycles, response 5 cycles later.
    bus.req_valid = 2'b10;
    bus.req_addr = {16'h0020, 16'h0000};
    bus.req_write = 2'b00;
    bus.csb2nvdla_ready = 1'b0;
    #1 chk("rd_req_ready", 32'(bus.req_ready), 32'b10);
    nxt();
    bus.req_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rd_stall_valid", 32'(bus.csb2nvdla_valid), 32'd1);
      chk("rd_stall_addr", 32'(bus.csb2nvdla_addr), 32'h0020);
      nxt();
    end
    bus.csb2nvdla_ready = 1'b1;
    #1 chk("rd_csb_write", 32'(bus.csb2nvdla_write), 32'd0);
    nxt();
    bus.csb2nvdla_ready = 1'b0;
    for (int i = 1; i < 5; i++) begin
      chk("rd_wait_no_rsp", 32'(bus.rsp_valid), 32'd0);
      nxt();
    end
    bus.nvdla2csb_valid = 1'b1;
    bus.nvdla2csb_data = 32'h1234_5678;
    nxt();
    bus.nvdla2csb_valid = 1'b0;
    bus.nvdla2csb_data = '0;
    chk("rd_rsp_valid", 32'(bus.rsp_valid), 32'b10);
    chk("rd_rsp_data", bus.rsp_data, 32'h1234_5678);
    chk("rd_rsp_error", 32'(bus.rsp_error), 32'd0);
    nxt();
    chk("rd_rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);

    // Fairness: both requesters stream posted writes.
    bus.req_valid = 2'b11;
    bus.req_addr = {16'h0200, 16'h0100};
    bus.req_wdat = {32'h2222_2222, 32'h1111_1111};
    bus.req_write = 2'b11;
    bus.req_nposted = 2'b00;
    bus.csb2nvdla_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (k % 2 == 0) begin
        chk("fair_req_ready", 32'(bus.req_ready), (k % 4 == 0) ? 32'b01 : 32'b10);
        chk("fair_idle_valid", 32'(bus.csb2nvdla_valid), 32'd0);
      end else begin
        chk("fair_csb_valid", 32'(bus.csb2nvdla_valid), 32'd1);
        chk("fair_csb_addr", 32'(bus.csb2nvdla_addr), (k % 4 == 1) ? 32'h0100 : 32'h0200);
      end
      nxt();
    end
    bus.req_valid = 2'b00;

    // Timeout on a read from requester 0.
    nxt();
    bus.req_valid = 2'b01;
    bus.req_addr = {16'h0000, 16'h0033};
    bus.req_write = 2'b00;
    #1 chk("to_req_ready", 32'(bus.req_ready), 32'b01);
    nxt();
    bus.req_valid = 2'b00;
    nxt();
    bus.csb2nvdla_ready = 1'b0;
    for (int i = 1; i < 16; i++) begin
      chk("to_wait_no_rsp", 32'(bus.rsp_valid), 32'd0);
      nxt();
    end
    chk("to_rsp_valid", 32'(bus.rsp_valid), 32'b01);
    chk("to_rsp_error", 32'(bus.rsp_error), 32'd1);
    chk("to_rsp_data", bus.rsp_data, 32'd0);
    nxt();
    nxt();
    nxt();
    bus.nvdla2csb_valid = 1'b1;
    bus.nvdla2csb_data = 32'h5555_AAAA;
    nxt();
    bus.nvdla2csb_valid = 1'b0;
    chk("to_stray_ignored0", 32'(bus.rsp_valid), 32'd0);
    nxt();
    chk("to_stray_ignored1", 32'(bus.rsp_valid), 32'd0);

    // Non-posted write from requester 1: only wr_complete answers it.
    bus.req_valid = 2'b10;
    bus.req_addr = {16'h0030, 16'h0000};
    bus.req_wdat = {32'hDEAD_BEEF, 32'h0};
    bus.req_write = 2'b10;
    bus.req_nposted = 2'b10;
    bus.csb2nvdla_ready = 1'b1;
    #1 chk("np_req_ready", 32'(bus.req_ready), 32'b10);
    nxt();
    bus.req_valid = 2'b00;
    #1 chk("np_csb_nposted", 32'(bus.csb2nvdla_nposted), 32'd1);
    chk("np_csb_wdat", bus.csb2nvdla_wdat, 32'hDEAD_BEEF);
    nxt();
    bus.csb2nvdla_ready = 1'b0;
    nxt();
    bus.nvdla2csb_valid = 1'b1;
    bus.nvdla2csb_data = 32'hCAFE_0000;
    nxt();
    bus.nvdla2csb_valid = 1'b0;
    nxt();
    chk("np_rdata_ignored", 32'(bus.rsp_valid), 32'd0);
    bus.nvdla2csb_wr_complete = 1'b1;
    nxt();
    bus.nvdla2csb_wr_complete = 1'b0;
    chk("np_rsp_valid", 32'(bus.rsp_valid), 32'b10);
    chk("np_rsp_data", bus.rsp_data, 32'd0);
    chk("np_rsp_error", 32'(bus.rsp_error), 32'd0);

    // Reset while waiting on a read from requester 0.
    nxt();
    bus.req_valid = 2'b01;
    bus.req_addr = {16'h0000, 16'h0040};
    bus.req_write = 2'b00;
    bus.req_nposted = 2'b00;
    bus.csb2nvdla_ready = 1'b1;
    #1 chk("mr_req_ready", 32'(bus.req_ready), 32'b01);
    nxt();
    bus.req_valid = 2'b00;
    nxt();
    bus.csb2nvdla_ready = 1'b0;
    nxt();
    prst = 1'b1;
    #1;
    chk("mr_csb_valid", 32'(bus.csb2nvdla_valid), 32'd0);
    chk("mr_csb_addr", 32'(bus.csb2nvdla_addr), 32'd0);
    chk("mr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mr_req_ready", 32'(bus.req_ready), 32'd0);
    #3 prst = 1'b0;
    nxt();
    bus.req_valid = 2'b11;
    bus.req_addr = {16'h0200, 16'h0100};
    bus.req_write = 2'b11;
    bus.req_nposted = 2'b00;
    bus.csb2nvdla_ready = 1'b1;
    bus.nvdla2csb_valid = 1'b1;
    bus.nvdla2csb_data = 32'h7777_7777;
    #1 chk("mr_first_winner", 32'(bus.req_ready), 32'b01);
    nxt();
    bus.req_valid = 2'b00;
    bus.nvdla2csb_valid = 1'b0;
    #1;
    chk("mr_late_rsp_ignored", 32'(bus.rsp_valid), 32'd0);
    chk("mr_csb_addr_after", 32'(bus.csb2nvdla_addr), 32'h0100);
    nxt();
    chk("mr_late_rsp_ignored1", 32'(bus.rsp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
